lcd_write_ctrl: RTL and testbench
=================================

Name: lcd_write_ctrl

Overview:
Responder end of the LCD write interface that the CPU top's command queue drives. It accepts one 9-bit command/data word per WRITE strobe and reports busy on STATUS. It then sequences the HD44780-style 8-bit parallel bus: RS/RW setup, EN pulse, hold, and the controller execution wait. The block sits between the command queue and the LCD_* board pins.

Parameters:
PWRUP_CYC, 750000, power-up wait after reset before the first write is accepted (15 ms at 50 MHz)
SETUP_CYC, 4, RS/RW/DATA stable cycles before EN rises
EN_CYC, 24, EN high width in cycles
HOLD_CYC, 4, RS/RW/DATA stable cycles after EN falls
EXEC_CYC, 2000, post-write wait for normal commands and data (40 us)
CLR_EXEC_CYC, 82000, post-write wait for clear/home, i.e. RS=0 and WRDATA[7:0] in {0x01,0x02,0x03} (1.64 ms)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
WRITE  in  1  write strobe; accepted only when STATUS=0
WRDATA  in  9  bit8 = RS (1 data, 0 command), bits7:0 = byte
STATUS  out  1  1 = busy or not yet ready; new WRITE ignored
LCD_BLON  out  1  backlight enable
LCD_RW  out  1  0 write, 1 read
LCD_EN  out  1  enable strobe
LCD_RS  out  1  register select
LCD_DATA  inout  8  LCD data bus; driven when LCD_RW=0, high-Z otherwise

Behaviour:
- Clocking and reset: one clock domain (clk). rst is synchronous and active-high.
- Reset values: STATUS=1, LCD_EN=0, LCD_RW=0, LCD_RS=0, LCD_BLON=0, LCD_DATA driven 0x00. State goes to PWRUP, counter loads PWRUP_CYC-1.
- A reset asserted mid-transfer aborts the transfer: EN drops on the next edge and the power-up wait restarts.
- LCD_BLON goes to 1 on the first cycle after reset and stays 1.
- All counters are 20 bits. Each state loads its counter on entry, decrements every cycle, and exits when the counter reaches 0. A state therefore lasts exactly its *_CYC cycles.
- PWRUP: STATUS=1. Goes to IDLE after PWRUP_CYC cycles.
- IDLE: STATUS=0 (registered output).
  - WRITE=1 in IDLE: latch WRDATA into RS/DATA registers, set the clear flag (RS=0 and byte in 0x01..0x03), go to SETUP.
  - STATUS=1 from the cycle after the accepting edge.
- SETUP: LCD_RS/LCD_DATA show the latched word, LCD_RW=0, EN=0. Lasts SETUP_CYC cycles, then PULSE.
- PULSE: EN=1 for EN_CYC cycles, then HOLD.
- HOLD: EN=0, bus unchanged for HOLD_CYC cycles, then EXEC.
- EXEC: bus unchanged. Wait CLR_EXEC_CYC cycles if the clear flag is set, else EXEC_CYC cycles. Then IDLE with STATUS=0.
- WRITE while STATUS=1 is ignored with no side effects; the producer must hold its word. STATUS is high in every state except IDLE.
- WRITE held high across several IDLE cycles: only the first cycle is accepted. The block re-enters IDLE only after a full sequence, so a continuous WRITE level produces back-to-back transfers of whatever WRDATA shows at each acceptance.
- Minimum transfer length: SETUP+EN+HOLD+EXEC cycles, plus 1 cycle in IDLE.
- LCD_EN is registered and glitch-free. RS, RW and DATA never change while EN=1.

Optional Feature:
LCD_BUSY_POLL_EN.
- Defined: EXEC is replaced by a busy-flag poll loop:
  - POLL_SETUP: RW=1, RS=0, LCD_DATA high-Z for SETUP_CYC cycles.
  - POLL_PULSE: EN=1 for EN_CYC cycles; LCD_DATA[7] is sampled on the last EN-high cycle.
  - POLL_HOLD: HOLD_CYC cycles.
  - If the sampled BF=1, repeat the loop. If BF=0, go to IDLE with RW=0 and the bus driven again.
  - A timeout counter limits polling to CLR_EXEC_CYC cycles total; on expiry go to IDLE.
- Undefined: fixed EXEC wait only, LCD_RW is constant 0 after reset, and LCD_DATA is never tri-stated.

Test Plan:
- Power-up (params 8/2/3/2/10/40): release rst -> STATUS=1 for exactly 8 cycles, then 0; LCD_BLON=1 from the first post-reset cycle; no EN activity.
- Single data write WRITE with WRDATA=0x141 -> STATUS=1 next cycle; LCD_RS=1, LCD_DATA=0x41; EN high exactly 3 cycles starting 2 cycles after acceptance; STATUS back to 0 after 2+3+2+10 cycles.
- Clear command WRDATA=0x001 -> EXEC lasts 40 cycles; WRDATA=0x080 -> EXEC lasts 10 cycles.
- WRITE pulses with 0x138 during EXEC -> ignored; LCD_DATA stays at the prior byte; exactly one EN pulse is seen.
- rst asserted during PULSE -> EN=0 the next cycle, STATUS=1, power-up wait of 8 cycles repeats.
- LCD_BUSY_POLL_EN with a bench model returning BF=1 for 2 polls then 0 -> three RW=1 EN pulses after the write pulse, LCD_DATA high-Z during the polls, then STATUS=0.

Source files
------------

// File: rtl/lcd_write_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_write_ctrl
// Accepts 9-bit command/data words from the command queue and sequences the
// HD44780-style 8-bit parallel write: setup, EN pulse, hold, execution wait.
// Optional macro LCD_BUSY_POLL_EN replaces the fixed execution wait with a
// busy-flag read loop bounded by CLR_EXEC_CYC cycles.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lcd_write_ctrl #(
  parameter int PWRUP_CYC    = 750000,
  parameter int SETUP_CYC    = 4,
  parameter int EN_CYC       = 24,
  parameter int HOLD_CYC     = 4,
  parameter int EXEC_CYC     = 2000,
  parameter int CLR_EXEC_CYC = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       WRITE,
  input  logic [8:0] WRDATA,
  output logic       STATUS,
  output logic       LCD_BLON,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS,
  inout  wire  [7:0] LCD_DATA
);

  localparam logic [3:0] ST_PWRUP  = 4'd0;
  localparam logic [3:0] ST_IDLE   = 4'd1;
  localparam logic [3:0] ST_SETUP  = 4'd2;
  localparam logic [3:0] ST_PULSE  = 4'd3;
  localparam logic [3:0] ST_HOLD   = 4'd4;
`ifdef LCD_BUSY_POLL_EN
  localparam logic [3:0] ST_PSETUP = 4'd5;
  localparam logic [3:0] ST_PPULSE = 4'd6;
  localparam logic [3:0] ST_PHOLD  = 4'd7;
`else
  localparam logic [3:0] ST_EXEC   = 4'd5;
  localparam logic [19:0] LD_EXEC  = 20'(EXEC_CYC - 1);
`endif

  // Counter load values: a state lasting N cycles loads N-1 and exits at 0.
  localparam logic [19:0] LD_PWRUP = 20'(PWRUP_CYC - 1);
  localparam logic [19:0] LD_SETUP = 20'(SETUP_CYC - 1);
  localparam logic [19:0] LD_EN    = 20'(EN_CYC - 1);
  localparam logic [19:0] LD_HOLD  = 20'(HOLD_CYC - 1);
  localparam logic [19:0] LD_CLR   = 20'(CLR_EXEC_CYC - 1);

  logic [3:0]  state, state_nx;
  logic [19:0] cnt, cnt_nx;
  logic        busy, busy_nx;
  logic        en, en_nx;
  logic        rw, rw_nx;
  logic        blon;
  logic        rs_lat;
  logic [7:0]  data_lat;
  logic        accept;

`ifdef LCD_BUSY_POLL_EN
  logic [19:0] tmo, tmo_nx;
  logic        bf;
`else
  logic        clr;
`endif

  assign accept = (state == ST_IDLE) && WRITE;

  // State register plus registered outputs, so EN/STATUS/RW never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_PWRUP;
      cnt   <= LD_PWRUP;
      busy  <= 1'b1;
      en    <= 1'b0;
      rw    <= 1'b0;
      blon  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      busy  <= busy_nx;
      en    <= en_nx;
      rw    <= rw_nx;
      blon  <= 1'b1;
    end
  end

  // Latch the accepted word; it stays on the bus until the next acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      rs_lat   <= 1'b0;
      data_lat <= 8'h00;
`ifndef LCD_BUSY_POLL_EN
      clr      <= 1'b0;
`endif
    end else if (accept) begin
      rs_lat   <= WRDATA[8];
      data_lat <= WRDATA[7:0];
`ifndef LCD_BUSY_POLL_EN
      clr      <= !WRDATA[8] && (WRDATA[7:0] inside {8'h01, 8'h02, 8'h03});
`endif
    end
  end

`ifdef LCD_BUSY_POLL_EN
  // Busy flag sampled on the last EN-high cycle of a read; timeout bounds polling.
  always_ff @(posedge clk) begin
    if (rst) begin
      bf  <= 1'b0;
      tmo <= '0;
    end else begin
      tmo <= tmo_nx;
      if (state == ST_PPULSE && cnt == '0) begin
        bf <= LCD_DATA[7];
      end
    end
  end
`endif

  // Next-state and counter sequencing.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt - 20'd1;
`ifdef LCD_BUSY_POLL_EN
    tmo_nx   = tmo;
`endif
    case (state)
      ST_PWRUP: begin
        if (cnt == '0) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end
      end
      ST_IDLE: begin
        cnt_nx = cnt;
        if (WRITE) begin
          state_nx = ST_SETUP;
          cnt_nx   = LD_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt == '0) begin
          state_nx = ST_PULSE;
          cnt_nx   = LD_EN;
        end
      end
      ST_PULSE: begin
        if (cnt == '0) begin
          state_nx = ST_HOLD;
          cnt_nx   = LD_HOLD;
        end
      end
`ifdef LCD_BUSY_POLL_EN
      ST_HOLD: begin
        if (cnt == '0) begin
          state_nx = ST_PSETUP;
          cnt_nx   = LD_SETUP;
          tmo_nx   = LD_CLR;
        end
      end
      ST_PSETUP, ST_PPULSE, ST_PHOLD: begin
        tmo_nx = tmo - 20'd1;
        if (cnt == '0) begin
          if (state == ST_PSETUP) begin
            state_nx = ST_PPULSE;
            cnt_nx   = LD_EN;
          end else if (state == ST_PPULSE) begin
            state_nx = ST_PHOLD;
            cnt_nx   = LD_HOLD;
          end else if (bf) begin
            state_nx = ST_PSETUP;
            cnt_nx   = LD_SETUP;
          end else begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
          end
        end
        // Timeout wins over any pending step of the loop.
        if (tmo == '0) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end
      end
`else
      ST_HOLD: begin
        if (cnt == '0) begin
          state_nx = ST_EXEC;
          cnt_nx   = clr ? LD_CLR : LD_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt == '0) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end
      end
`endif
      default: begin
        state_nx = ST_PWRUP;
        cnt_nx   = LD_PWRUP;
      end
    endcase
  end

  // Output decode from the next state; registered in the state process.
  always_comb begin
    busy_nx = (state_nx != ST_IDLE);
`ifdef LCD_BUSY_POLL_EN
    en_nx   = (state_nx == ST_PULSE) || (state_nx == ST_PPULSE);
    rw_nx   = (state_nx == ST_PSETUP) || (state_nx == ST_PPULSE) ||
              (state_nx == ST_PHOLD);
`else
    en_nx   = (state_nx == ST_PULSE);
    rw_nx   = 1'b0;
`endif
  end

  assign STATUS   = busy;
  assign LCD_BLON = blon;
  assign LCD_EN   = en;
  assign LCD_RW   = rw;
  // RS is forced to 0 during busy-flag reads; the bus is released while reading.
  assign LCD_RS   = rw ? 1'b0 : rs_lat;
  assign LCD_DATA = rw ? 8'hzz : data_lat;

endmodule

`default_nettype wire

// File: tb/tb_lcd_write_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lcd_write_ctrl
// Directed bench: expected EN pulses are queued when a write is issued and
// checked by a bus monitor when each pulse ends.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lcd_write_ctrl;

  localparam int PWRUP_CYC    = 8;
  localparam int SETUP_CYC    = 2;
  localparam int EN_CYC       = 3;
  localparam int HOLD_CYC     = 2;
  localparam int EXEC_CYC     = 10;
  localparam int CLR_EXEC_CYC = 40;
  localparam int SEQ_CYC      = SETUP_CYC + EN_CYC + HOLD_CYC;

  typedef struct {
    logic       rs;
    logic       rw;
    logic [7:0] data;
    int         width;
    int         delay;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       WRITE = 1'b0;
  logic [8:0] WRDATA = 9'h000;
  logic       STATUS, LCD_BLON, LCD_RW, LCD_EN, LCD_RS;
  wire  [7:0] lcd_data;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  int   pulses = 0;
  int   poll_cnt = 0;
  exp_t exp_q[$];

  // Display controller model: answers busy-flag reads, BF=1 for the first two.
  assign lcd_data = (LCD_RW && LCD_EN) ? {(poll_cnt < 2), 7'h00} : 8'hzz;

  lcd_write_ctrl #(
    .PWRUP_CYC(PWRUP_CYC), .SETUP_CYC(SETUP_CYC), .EN_CYC(EN_CYC),
    .HOLD_CYC(HOLD_CYC), .EXEC_CYC(EXEC_CYC), .CLR_EXEC_CYC(CLR_EXEC_CYC)
  ) dut (
    .clk(clk), .rst(rst), .WRITE(WRITE), .WRDATA(WRDATA), .STATUS(STATUS),
    .LCD_BLON(LCD_BLON), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .LCD_RS(LCD_RS),
    .LCD_DATA(lcd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Count negedges with STATUS still high; bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (STATUS !== 1'b0 && n < 500) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Called at a negedge with STATUS=0; returns at the negedge after acceptance.
  task automatic write_word(input logic [8:0] w);
    exp_t e;
    e.rs = w[8]; e.rw = 1'b0; e.data = w[7:0]; e.width = EN_CYC; e.delay = SETUP_CYC;
    exp_q.push_back(e);
`ifdef LCD_BUSY_POLL_EN
    for (int i = 0; i < 3; i++) begin
      e.rs = 1'b0; e.rw = 1'b1; e.data = 8'h00; e.width = EN_CYC; e.delay = 0;
      exp_q.push_back(e);
    end
    poll_cnt = 0;
`endif
    WRITE = 1'b1;
    WRDATA = w;
    @(negedge clk);
    WRITE = 1'b0;
    accept_cyc = cyc;
    check("status_after_accept", {31'd0, STATUS}, 32'd1);
  endtask

  function automatic int exp_busy(input logic [8:0] w);
`ifdef LCD_BUSY_POLL_EN
    return SEQ_CYC * 4 + 0 * int'(w[0]);
`else
    if (!w[8] && (w[7:0] == 8'h01 || w[7:0] == 8'h02 || w[7:0] == 8'h03))
      return SEQ_CYC + CLR_EXEC_CYC;
    return SEQ_CYC + EXEC_CYC;
`endif
  endfunction

  // Bus monitor: captures each EN pulse and compares it against the queue.
  initial begin
    logic       en_prev = 1'b0;
    logic       cap_rs = 1'b0, cap_rw = 1'b0, stable = 1'b1;
    logic [7:0] cap_data = 8'h00;
    int         width = 0, rise_cyc = 0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (LCD_EN === 1'b1 && !en_prev) begin
        rise_cyc = cyc; cap_rs = LCD_RS; cap_rw = LCD_RW; cap_data = lcd_data;
        stable = 1'b1; width = 1;
      end else if (LCD_EN === 1'b1) begin
        width++;
        if (LCD_RS !== cap_rs || LCD_RW !== cap_rw || (!cap_rw && lcd_data !== cap_data))
          stable = 1'b0;
      end else if (en_prev) begin
        pulses++;
        if (exp_q.size() == 0) begin
          check("unexpected_en_pulse", {24'd0, cap_data}, 32'hffff_ffff);
        end else begin
          e = exp_q.pop_front();
          check("en_rs", {31'd0, cap_rs}, {31'd0, e.rs});
          check("en_rw", {31'd0, cap_rw}, {31'd0, e.rw});
          check("en_width", width, e.width);
          check("bus_stable_during_en", {31'd0, stable}, 32'd1);
          if (!e.rw) begin
            check("en_data", {24'd0, cap_data}, {24'd0, e.data});
            check("en_delay", rise_cyc - accept_cyc, e.delay);
          end
          if (cap_rw) poll_cnt++;
        end
      end
      en_prev = (LCD_EN === 1'b1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   p0;
    exp_t e;
    logic [8:0] words [4] = '{9'h003, 9'h004, 9'h103, 9'h080};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_status", {31'd0, STATUS}, 32'd1);
    check("rst_en", {31'd0, LCD_EN}, 32'd0);
    check("rst_rw", {31'd0, LCD_RW}, 32'd0);
    check("rst_rs", {31'd0, LCD_RS}, 32'd0);
    check("rst_blon", {31'd0, LCD_BLON}, 32'd0);
    check("rst_data", {24'd0, lcd_data}, 32'd0);

    // Power-up wait
    rst = 1'b0;
    wait_idle(n);
    check("pwrup_cycles", n, PWRUP_CYC);
    check("blon_after_reset", {31'd0, LCD_BLON}, 32'd1);
    check("no_en_in_pwrup", pulses, 0);

    // Single data write
    write_word(9'h141);
    check("rs_shown", {31'd0, LCD_RS}, 32'd1);
    check("data_shown", {24'd0, lcd_data}, 32'h41);
    wait_idle(n);
    check("busy_0x141", n, exp_busy(9'h141));

    // Clear boundary and normal commands
    write_word(9'h001);
    wait_idle(n);
    check("busy_0x001", n, exp_busy(9'h001));
    for (int i = 0; i < 4; i++) begin
      write_word(words[i]);
      wait_idle(n);
      check("busy_word", n, exp_busy(words[i]));
    end

    // WRITE during the post-write wait is ignored
    p0 = pulses;
    write_word(9'h142);
    repeat (SEQ_CYC + 2) @(negedge clk);
    WRITE = 1'b1;
    WRDATA = 9'h138;
    repeat (2) @(negedge clk);
    WRITE = 1'b0;
    check("status_busy_ignored", {31'd0, STATUS}, 32'd1);
`ifndef LCD_BUSY_POLL_EN
    check("data_kept_ignored", {24'd0, lcd_data}, 32'h42);
`endif
    wait_idle(n);
    check("data_after_ignored", {24'd0, lcd_data}, 32'h42);
    check("one_write_pulse", pulses - p0, 1 + (exp_busy(9'h142) - SEQ_CYC - EXEC_CYC) / SEQ_CYC * 0
`ifdef LCD_BUSY_POLL_EN
          + 3
`endif
          );

    // Reset during the EN pulse
    write_word(9'h155);
    n = 0;
    while (LCD_EN !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("en_seen_before_reset", {31'd0, LCD_EN}, 32'd1);
    e = exp_q[0];
    e.width = 1;
    exp_q.delete();
    exp_q.push_back(e);
    rst = 1'b1;
    @(negedge clk);
    check("en_dropped_on_reset", {31'd0, LCD_EN}, 32'd0);
    check("status_on_reset", {31'd0, STATUS}, 32'd1);
    rst = 1'b0;
    wait_idle(n);
    check("pwrup_after_abort", n, PWRUP_CYC);

`ifdef LCD_BUSY_POLL_EN
    // Busy-flag polling: bus released during reads
    write_word(9'h120);
    n = 0;
    while (LCD_RW !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("poll_rw", {31'd0, LCD_RW}, 32'd1);
    check("poll_rs", {31'd0, LCD_RS}, 32'd0);
    check("poll_data_hiz", {24'd0, lcd_data}, 32'h0000_00zz);
    wait_idle(n);
    check("poll_busy", n, SEQ_CYC * 3);
    check("poll_count", poll_cnt, 3);
    check("rw_after_poll", {31'd0, LCD_RW}, 32'd0);
    check("data_driven_after_poll", {24'd0, lcd_data}, 32'h20);
`endif

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
